// File: rtl/hazard_scoreboard_if.sv
// Decoder <-> hazard scoreboard connection: issue request, source operands,
// flush, and the stall / forwarding / counter results.
interface hazard_scoreboard_if #(
   parameter int ADDR_W = 5,
   parameter int LAT_W  = 2,
   parameter int SEL_W  = 3,
   parameter int CNT_W  = 16
);
   logic              issue_valid;
   logic              issue_we;
   logic [ADDR_W-1:0] issue_rd;
   logic [LAT_W-1:0]  issue_lat;
   logic [ADDR_W-1:0] rs1;
   logic [ADDR_W-1:0] rs2;
   logic              rs1_used;
   logic              rs2_used;
   logic              flush;
   logic              stall;
   logic              issue_ok;
   logic [SEL_W-1:0]  fwd1_sel;
   logic [SEL_W-1:0]  fwd2_sel;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output issue_valid, issue_we, issue_rd, issue_lat,
      output rs1, rs2, rs1_used, rs2_used, flush,
      input  stall, issue_ok, fwd1_sel, fwd2_sel, stall_cnt
   );

   modport slave (
      input  issue_valid, issue_we, issue_rd, issue_lat,
      input  rs1, rs2, rs1_used, rs2_used, flush,
      output stall, issue_ok, fwd1_sel, fwd2_sel, stall_cnt
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// In-flight instruction tracker: age-ordered table of pending writebacks that
// drives the decode stall, per-source forwarding selects and branch squash.
module hazard_scoreboard #(
   parameter int NREGS       = 32,
   parameter int ADDR_W      = 5,
   parameter int DEPTH       = 4,
   parameter int MAX_LAT     = 2,
   parameter int FLUSH_DEPTH = 2,
   parameter int CNT_W       = 16
) (
   input logic               clk,
   input logic               reset,
   hazard_scoreboard_if.slave sb
);
   localparam int LAT_W = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);
   localparam int SEL_W = $clog2(DEPTH + 1);
   localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);

   typedef struct packed {
      logic              v;
      logic [ADDR_W-1:0] rd;
      logic [LAT_W-1:0]  rem;
   } slot_t;

   slot_t             r_slot [DEPTH];
   logic [CNT_W-1:0]  r_stall_cnt;

   logic [ADDR_W-1:0] w_src      [2];
   logic              w_src_used [2];
   logic              w_hit      [2];
   logic              w_ready    [2];
   logic [SEL_W-1:0]  w_idx      [2];
   logic              w_hazard   [2];
   logic [SEL_W-1:0]  w_sel      [2];
   logic              w_stall;
   logic              w_issue_ok;
   logic              w_load;
   logic [LAT_W-1:0]  w_lat;

   assign w_src[0]      = sb.rs1;
   assign w_src[1]      = sb.rs2;
   assign w_src_used[0] = sb.rs1_used;
   assign w_src_used[1] = sb.rs2_used;

   // Scan oldest to youngest so the youngest matching producer wins.
   // NOTE: every always_comb output gets a default first, otherwise a path that skips the assignment infers a latch.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         w_hit[s]    = 1'b0;
         w_ready[s]  = 1'b0;
         w_idx[s]    = '0;
         w_hazard[s] = 1'b0;
         w_sel[s]    = '0;
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (r_slot[k].v && (r_slot[k].rd == w_src[s])) begin
               w_hit[s]   = 1'b1;
               w_ready[s] = (r_slot[k].rem == '0);
               w_idx[s]   = SEL_W'(k);
            end
         end
         if (w_src_used[s] && (w_src[s] != '0) && w_hit[s]) begin
            w_hazard[s] = !w_ready[s];
            w_sel[s]    = w_ready[s] ? (w_idx[s] + SEL_W'(1)) : '0;
         end
      end
   end

   assign w_stall    = sb.issue_valid && !sb.flush && (w_hazard[0] || w_hazard[1]);
   assign w_issue_ok = sb.issue_valid && !w_stall && !sb.flush;
   assign w_load     = w_issue_ok && sb.issue_we && (sb.issue_rd != '0);
   assign w_lat      = (sb.issue_lat > MAX_LAT_V) ? MAX_LAT_V : sb.issue_lat;

   assign sb.stall     = w_stall;
   assign sb.issue_ok  = w_issue_ok;
   assign sb.fwd1_sel  = w_sel[0];
   assign sb.fwd2_sel  = w_sel[1];
   assign sb.stall_cnt = r_stall_cnt;

   // Every slot, including rd/rem, is cleared on reset: the table is tiny and
   // a known-clean state keeps pre-reset entries from ever matching.
   // NOTE: sequential state uses non-blocking assignments so all slots shift from the same pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_slot[i] <= '0;
         end
         r_stall_cnt <= '0;
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            r_slot[i].v   <= r_slot[i-1].v && !(sb.flush && ((i - 1) < FLUSH_DEPTH));
            r_slot[i].rd  <= r_slot[i-1].rd;
            r_slot[i].rem <= (r_slot[i-1].rem == '0) ? '0 : (r_slot[i-1].rem - LAT_W'(1));
         end
         if (w_load) begin
            r_slot[0] <= '{v: 1'b1, rd: sb.issue_rd, rem: w_lat};
         end else begin
            r_slot[0] <= '0;
         end
         if (w_stall && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a per-cycle vector table followed by a
// hand-written asynchronous mid-operation reset sequence.
module tb_hazard_scoreboard;
   logic clk;
   logic reset;

   hazard_scoreboard_if #(.ADDR_W(5), .LAT_W(2), .SEL_W(3), .CNT_W(16)) bus ();

   hazard_scoreboard #(
      .NREGS(32), .ADDR_W(5), .DEPTH(4), .MAX_LAT(2), .FLUSH_DEPTH(2), .CNT_W(16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .sb    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        v;
      logic        we;
      logic [4:0]  rd;
      logic [1:0]  lat;
      logic [4:0]  a;
      logic        ua;
      logic [4:0]  b;
      logic        ub;
      logic        fl;
      logic        e_stall;
      logic        e_ok;
      logic [2:0]  e_sel1;
      logic [2:0]  e_sel2;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs[$];
   int   n_vec;
   int   n_err;

   function automatic vec_t mk(input int rst, v, we, rd, lat, a, ua, b, ub, fl,
                               es, eo, e1, e2, ec);
      vec_t t;
      t.rst = rst[0];  t.v  = v[0];     t.we = we[0];
      t.rd  = rd[4:0]; t.lat = lat[1:0];
      t.a   = a[4:0];  t.ua = ua[0];    t.b  = b[4:0];  t.ub = ub[0];
      t.fl  = fl[0];
      t.e_stall = es[0]; t.e_ok = eo[0];
      t.e_sel1  = e1[2:0]; t.e_sel2 = e2[2:0]; t.e_cnt = ec[15:0];
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      reset           = !t.rst;
      bus.issue_valid = t.v;
      bus.issue_we    = t.we;
      bus.issue_rd    = t.rd;
      bus.issue_lat   = t.lat;
      bus.rs1         = t.a;
      bus.rs1_used    = t.ua;
      bus.rs2         = t.b;
      bus.rs2_used    = t.ub;
      bus.flush       = t.fl;
   endtask

   task automatic check_outputs(input string tag, input vec_t t);
      check({tag, " stall"},     32'(bus.stall),     32'(t.e_stall));
      check({tag, " issue_ok"},  32'(bus.issue_ok),  32'(t.e_ok));
      check({tag, " fwd1_sel"},  32'(bus.fwd1_sel),  32'(t.e_sel1));
      check({tag, " fwd2_sel"},  32'(bus.fwd2_sel),  32'(t.e_sel2));
      check({tag, " stall_cnt"}, 32'(bus.stall_cnt), 32'(t.e_cnt));
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      drive(mk(1, 0,0,0,0, 0,0,0,0,0, 0,0,0,0,0));

      //           rst v we rd lat  a ua  b ub fl  stl ok s1 s2 cnt
      vecs.push_back(mk(1, 1,0, 0,0,  5,1, 0,0, 0,  0,1, 0,0, 0)); // in reset
      vecs.push_back(mk(0, 0,0, 0,0,  0,0, 0,0, 0,  0,0, 0,0, 0)); // released
      vecs.push_back(mk(0, 1,1, 5,0,  0,0, 0,0, 0,  0,1, 0,0, 0)); // ALU rd5
      vecs.push_back(mk(0, 1,0, 0,0,  5,1, 0,0, 0,  0,1, 1,0, 0));
      vecs.push_back(mk(0, 1,1, 6,0,  5,1, 0,0, 0,  0,1, 2,0, 0));
      vecs.push_back(mk(0, 0,0, 0,0,  5,1, 6,1, 0,  0,0, 3,1, 0));
      vecs.push_back(mk(0, 0,0, 0,0,  5,1, 6,1, 0,  0,0, 4,2, 0)); // oldest slot
      vecs.push_back(mk(0, 0,0, 0,0,  5,1, 6,1, 0,  0,0, 0,3, 0)); // rd5 aged out
      vecs.push_back(mk(0, 0,0, 0,0,  0,0, 6,1, 0,  0,0, 0,4, 0));
      vecs.push_back(mk(0, 1,1, 7,1,  0,0, 0,0, 0,  0,1, 0,0, 0)); // load rd7
      vecs.push_back(mk(0, 1,1, 8,0,  0,0, 7,1, 0,  1,0, 0,0, 0)); // load-use
      vecs.push_back(mk(0, 1,1, 8,0,  0,0, 7,1, 0,  0,1, 0,2, 1));
      vecs.push_back(mk(0, 1,1, 3,0,  8,1, 0,0, 0,  0,1, 1,0, 1));
      vecs.push_back(mk(0, 1,1, 3,0,  0,0, 7,1, 0,  0,1, 0,4, 1));
      vecs.push_back(mk(0, 0,0, 0,0,  3,1, 8,1, 0,  0,0, 1,3, 1)); // youngest wins
      vecs.push_back(mk(0, 1,1, 0,2,  3,1, 0,0, 0,  0,1, 2,0, 1)); // x0 write
      vecs.push_back(mk(0, 0,0, 0,0,  0,1, 3,1, 0,  0,0, 0,3, 1)); // rs1=x0
      vecs.push_back(mk(0, 1,1, 4,2,  0,0, 3,1, 0,  0,1, 0,4, 1));
      vecs.push_back(mk(0, 1,0, 0,0,  4,0, 4,0, 0,  0,1, 0,0, 1)); // unused srcs
      vecs.push_back(mk(0, 1,0, 0,0,  4,1, 0,0, 0,  1,0, 0,0, 1));
      vecs.push_back(mk(0, 1,0, 0,0,  4,1, 0,0, 0,  0,1, 3,0, 2));
      vecs.push_back(mk(0, 1,1,10,3,  4,1, 0,0, 0,  0,1, 4,0, 2)); // lat clamp
      vecs.push_back(mk(0, 1,1,11,0, 10,1,10,1, 0,  1,0, 0,0, 2)); // rs1==rs2
      vecs.push_back(mk(0, 1,1,11,0, 10,1,10,1, 0,  1,0, 0,0, 3));
      vecs.push_back(mk(0, 1,1,11,0, 10,1,10,1, 0,  0,1, 3,3, 4));
      vecs.push_back(mk(0, 0,0, 0,0,  0,0,11,1, 0,  0,0, 0,1, 4));
      vecs.push_back(mk(0, 1,1, 9,2,  0,0,11,1, 0,  0,1, 0,2, 4));
      vecs.push_back(mk(0, 1,1,12,0,  9,1,11,1, 1,  0,0, 0,3, 4)); // flush
      vecs.push_back(mk(0, 1,0, 0,0,  9,1,11,1, 0,  0,1, 0,4, 4)); // survivor

      repeat (2) @(negedge clk);
      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i]);
         #2;
         check_outputs($sformatf("v%0d", i), vecs[i]);
      end

      // Asynchronous reset in the middle of a cycle wipes a forwardable entry.
      @(negedge clk);
      drive(mk(0, 1,1,13,0, 0,0, 0,0, 0, 0,0,0,0,0));
      @(negedge clk);
      drive(mk(0, 0,0, 0,0, 13,1, 0,0, 0, 0,0,0,0,0));
      #2;
      check("pre-reset fwd1_sel", 32'(bus.fwd1_sel), 32'd1);
      check("pre-reset stall_cnt", 32'(bus.stall_cnt), 32'd4);
      #1 reset = 1'b0;
      #1;
      check("async reset fwd1_sel", 32'(bus.fwd1_sel), 32'd0);
      check("async reset stall_cnt", 32'(bus.stall_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #2;
      check("post-reset fwd1_sel", 32'(bus.fwd1_sel), 32'd0);
      check("post-reset stall", 32'(bus.stall), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
